// File: rtl/mpx_sample_pacer_pkg.sv
// Shared types and constants for the stereo multiplexer sample pacer.
package mpx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int UR_WIDTH           = 16;

    // One buffered stereo pair; this is the FIFO word.
    typedef struct packed {
        logic signed [DEFAULT_DATA_WIDTH-1:0] l;
        logic signed [DEFAULT_DATA_WIDTH-1:0] r;
    } stereo_sample_t;

    // Saturating increment for the underrun counter.
    function automatic logic [UR_WIDTH-1:0] sat_inc(input logic [UR_WIDTH-1:0] v);
        return (&v) ? v : v + UR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/mpx_sample_pacer_if.sv
// Stereo sample input stream: valid/ready handshake carrying one L/R pair.
interface mpx_sample_pacer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_l;
    logic [DATA_WIDTH-1:0] s_r;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_l, output s_r, output s_valid, input s_ready);
    modport slave  (input s_l, input s_r, input s_valid, output s_ready);
endinterface

// File: rtl/mpx_sample_pacer_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push is refused while full,
// even when a pop happens in the same cycle.
module sync_fifo
    import mpx_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = stereo_sample_t,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  T              wdata,
    input  logic          pop,
    output T              rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    T              mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage needs no reset; stale words are never read while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mpx_sample_pacer.sv
// Paces buffered stereo pairs out at one pair per programmable period,
// with in-phase and half-period strobes for the multiplexer.
module mpx_sample_pacer
    import mpx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          div,
    mpx_sample_pacer_if.slave             s_if,
    output logic [DATA_WIDTH-1:0]         out_l,
    output logic [DATA_WIDTH-1:0]         out_r,
    output logic                          out_valid,
    output logic                          out_valid_180,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [UR_WIDTH-1:0]           underrun_count,
    input  logic                          underrun_clr
);

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] l;
        logic signed [DATA_WIDTH-1:0] r;
    } pair_t;

    pair_t                wr_pair;
    pair_t                head;
    logic                 full;
    logic                 empty;
    logic                 tick;
    logic                 pop;
    logic [DIV_WIDTH-1:0] phase;
    logic [DIV_WIDTH-1:0] period;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [DIV_WIDTH-1:0] period_cur;

    assign wr_pair      = '{l: s_if.s_l, r: s_if.s_r};
    assign s_if.s_ready = !full;

    // Periods below 2 cannot host both strobes, so clamp.
    assign div_eff    = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;
    // A new divider only takes hold at the start of a period.
    assign period_cur = (phase == '0) ? div_eff : period;
    assign tick       = enable && (phase == '0);
    assign pop        = tick && !empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (pair_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_if.s_valid),
        .wdata (wr_pair),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Phase counter and latched period; disabled pacer parks at phase 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase  <= '0;
            period <= DIV_WIDTH'(2);
        end else begin
            if (phase == '0) period <= div_eff;
            if (!enable)
                phase <= '0;
            else if (phase == period_cur - DIV_WIDTH'(1))
                phase <= '0;
            else
                phase <= phase + DIV_WIDTH'(1);
        end
    end

    // Registered strobes: out_valid on tick, out_valid_180 at mid-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_valid_180 <= 1'b0;
        end else begin
            out_valid     <= tick;
            out_valid_180 <= enable && (phase == (period_cur >> 1));
        end
    end

    // Output pair updates only on a successful pop; underrun holds it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_l <= '0;
            out_r <= '0;
        end else if (pop) begin
            out_l <= head.l;
            out_r <= head.r;
        end
    end

    // Underrun counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            underrun_count <= '0;
        else if (underrun_clr)
            underrun_count <= '0;
        else if (tick && empty)
            underrun_count <= sat_inc(underrun_count);
    end

endmodule

// File: tb/tb_mpx_sample_pacer.sv
// Randomized and directed bench for mpx_sample_pacer against a
// queue-based behavioural model of the pacing rules.
module tb_mpx_sample_pacer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] div;
    logic        underrun_clr;
    logic [15:0] out_l, out_r;
    logic        out_valid, out_valid_180;
    logic [3:0]  fifo_level;
    logic [15:0] underrun_count;

    mpx_sample_pacer_if #(.DATA_WIDTH(16)) s_if ();

    mpx_sample_pacer #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .div            (div),
        .s_if           (s_if.slave),
        .out_l          (out_l),
        .out_r          (out_r),
        .out_valid      (out_valid),
        .out_valid_180  (out_valid_180),
        .fifo_level     (fifo_level),
        .underrun_count (underrun_count),
        .underrun_clr   (underrun_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Behavioural model state
    logic [31:0] m_q[$];
    int          m_ph, m_per, m_cnt;
    logic [15:0] m_l, m_r;
    logic        m_ov, m_ov180;

    task automatic model_reset();
        m_q.delete();
        m_ph = 0; m_per = 2; m_cnt = 0;
        m_l = 0; m_r = 0; m_ov = 0; m_ov180 = 0;
    endtask

    // Advance the model by one clock using the current inputs, then clock DUT.
    task automatic step();
        int pe;
        bit tk, full, empty;
        pe = (m_ph == 0) ? ((div < 2) ? 2 : int'(div)) : m_per;
        if (m_ph == 0) m_per = pe;
        tk    = enable && (m_ph == 0);
        full  = (m_q.size() == 8);
        empty = (m_q.size() == 0);
        m_ov    = tk;
        m_ov180 = enable && (m_ph == pe / 2);
        if (tk && !empty) {m_l, m_r} = m_q.pop_front();
        if (underrun_clr) m_cnt = 0;
        else if (tk && empty && m_cnt < 65535) m_cnt++;
        if (s_if.s_valid && !full) m_q.push_back({s_if.s_l, s_if.s_r});
        m_ph = !enable ? 0 : ((m_ph == pe - 1) ? 0 : m_ph + 1);
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0; div = 16'd2; underrun_clr = 1'b0;
        s_if.s_valid = 1'b0; s_if.s_l = '0; s_if.s_r = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1; #1;
        checks++; if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_if.s_ready); end
        checks++; if (out_l !== 16'h0 || out_r !== 16'h0) begin errors++; $display("FAIL reset_out got=%h/%h exp=0/0", out_l, out_r); end
        checks++; if (out_valid !== 1'b0 || out_valid_180 !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", out_valid, out_valid_180); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL reset_underrun got=%0d exp=0", underrun_count); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int prev;
        bit first;
        do_reset();
        div = 16'd10;
        s_if.s_valid = 1'b1; s_if.s_l = 16'h1234; s_if.s_r = 16'hABCD;
        step();
        s_if.s_valid = 1'b0;
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL basic_level got=%0d exp=1", fifo_level); end
        enable = 1'b1;
        prev = -1; first = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++; if (out_valid !== m_ov || out_valid_180 !== m_ov180) begin errors++; $display("FAIL basic_strobes cyc=%0d got=%b%b exp=%b%b", cyc, out_valid, out_valid_180, m_ov, m_ov180); end
            checks++; if (out_l !== m_l || out_r !== m_r || underrun_count !== 16'(m_cnt)) begin errors++; $display("FAIL basic_data cyc=%0d got=%h/%h/%0d exp=%h/%h/%0d", cyc, out_l, out_r, underrun_count, m_l, m_r, m_cnt); end
            if (out_valid) begin
                if (first) begin
                    checks++; if (out_l !== 16'h1234 || out_r !== 16'hABCD || underrun_count !== 16'd0) begin errors++; $display("FAIL basic_first got=%h/%h/%0d exp=1234/abcd/0", out_l, out_r, underrun_count); end
                    first = 0;
                end else begin
                    checks++; if (cyc - prev !== 10) begin errors++; $display("FAIL basic_period got=%0d exp=10", cyc - prev); end
                end
                prev = cyc;
            end
            if (out_valid_180) begin
                checks++; if (cyc - prev !== 5) begin errors++; $display("FAIL basic_180_offset got=%0d exp=5", cyc - prev); end
            end
        end
    endtask

    task automatic test_fill();
        logic [31:0] exp_q[8];
        int k;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q[i] = $urandom;
            s_if.s_valid = 1'b1; {s_if.s_l, s_if.s_r} = exp_q[i];
            step();
        end
        checks++; if (fifo_level !== 4'd8 || s_if.s_ready !== 1'b0) begin errors++; $display("FAIL fill_full got=%0d/%b exp=8/0", fifo_level, s_if.s_ready); end
        {s_if.s_l, s_if.s_r} = $urandom;
        step();
        s_if.s_valid = 1'b0;
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fill_ninth got=%0d exp=8", fifo_level); end
        enable = 1'b1; div = 16'd4; k = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++; if (out_valid !== m_ov || fifo_level !== 4'(m_q.size()) || s_if.s_ready !== (m_q.size() < 8)) begin errors++; $display("FAIL fill_state cyc=%0d got=%b/%0d/%b exp=%b/%0d", cyc, out_valid, fifo_level, s_if.s_ready, m_ov, m_q.size()); end
            if (out_valid && k < 8) begin
                checks++; if ({out_l, out_r} !== exp_q[k]) begin errors++; $display("FAIL fill_order k=%0d got=%h exp=%h", k, {out_l, out_r}, exp_q[k]); end
                if (k == 0) begin
                    checks++; if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop got=%b exp=1", s_if.s_ready); end
                end
                k++;
            end
        end
        checks++; if (k !== 8) begin errors++; $display("FAIL fill_count got=%0d exp=8", k); end
    endtask

    task automatic test_underrun();
        int n;
        do_reset();
        enable = 1'b1; div = 16'd4; n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) n++;
            checks++; if (underrun_count !== 16'(m_cnt)) begin errors++; $display("FAIL under_track cyc=%0d got=%0d exp=%0d", cyc, underrun_count, m_cnt); end
        end
        checks++; if (n !== 10 || underrun_count !== 16'd10) begin errors++; $display("FAIL under_total got=%0d/%0d exp=10/10", n, underrun_count); end
        checks++; if (out_l !== 16'h0 || out_r !== 16'h0) begin errors++; $display("FAIL under_hold got=%h/%h exp=0/0", out_l, out_r); end
        enable = 1'b0; underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL under_clr got=%0d exp=0", underrun_count); end
    endtask

    task automatic test_min_div();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            div = 16'(d); enable = 1'b1;
            for (int i = 0; i < 12; i++) begin
                step();
                checks++; if (out_valid !== (i % 2 == 0) || out_valid_180 !== (i % 2 == 1)) begin errors++; $display("FAIL min_div d=%0d i=%0d got=%b%b", d, i, out_valid, out_valid_180); end
            end
            enable = 1'b0;
            step();
        end
    endtask

    task automatic test_div_change();
        bit eo, e180;
        do_reset();
        div = 16'd8; enable = 1'b1;
        for (int off = 1; off <= 20; off++) begin
            step();
            if (off == 4) div = 16'd3;
            eo   = (off == 1) || (off >= 9  && (off - 9)  % 3 == 0);
            e180 = (off == 5) || (off >= 10 && (off - 10) % 3 == 0);
            checks++; if (out_valid !== eo || out_valid_180 !== e180) begin errors++; $display("FAIL div_change off=%0d got=%b%b exp=%b%b", off, out_valid, out_valid_180, eo, e180); end
        end
    endtask

    task automatic test_random();
        do_reset();
        div = 16'(($urandom % 10));
        for (int i = 0; i < 400; i++) begin
            s_if.s_valid = ($urandom % 3) != 0;
            {s_if.s_l, s_if.s_r} = $urandom;
            enable = ($urandom % 10) != 0;
            underrun_clr = ($urandom % 30) == 0;
            if ($urandom % 20 == 0) div = 16'($urandom_range(0, 9));
            step();
            checks++;
            if (out_valid !== m_ov || out_valid_180 !== m_ov180 || out_l !== m_l || out_r !== m_r ||
                fifo_level !== 4'(m_q.size()) || underrun_count !== 16'(m_cnt) || s_if.s_ready !== (m_q.size() < 8)) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b%b %h/%h lvl=%0d ur=%0d exp=%b%b %h/%h lvl=%0d ur=%0d",
                         cyc, out_valid, out_valid_180, out_l, out_r, fifo_level, underrun_count,
                         m_ov, m_ov180, m_l, m_r, m_q.size(), m_cnt);
            end
        end
        s_if.s_valid = 1'b0; underrun_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_if.s_valid = 1'b1; {s_if.s_l, s_if.s_r} = $urandom | 32'h0001_0001;
            step();
        end
        s_if.s_valid = 1'b0;
        enable = 1'b1; div = 16'd6; n = 0;
        step();
        while (!out_valid && n < 10) begin step(); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_wait_out_valid got=%b exp=1", out_valid); end
        step();
        checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL mid_level_before got=%0d exp=3", fifo_level); end
        #2 reset = 1'b1;
        #1;
        checks++; if (fifo_level !== 4'd0 || s_if.s_ready !== 1'b1) begin errors++; $display("FAIL mid_fifo got=%0d/%b exp=0/1", fifo_level, s_if.s_ready); end
        checks++; if (out_l !== 16'h0 || out_r !== 16'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_out got=%h/%h/%b exp=0/0/0", out_l, out_r, out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid_180 !== 1'b0) begin errors++; $display("FAIL mid_no_180 i=%0d got=%b exp=0", i, out_valid_180); end
        end
        model_reset();
        enable = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; div = 16'd2; underrun_clr = 1'b0;
        s_if.s_valid = 1'b0; s_if.s_l = '0; s_if.s_r = '0;
        test_reset();
        test_basic();
        test_fill();
        test_underrun();
        test_min_div();
        test_div_change();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
